// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrating multiplexer.
package arb_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_rr.sv
// Round-robin grant: first requester at or after ptr, searching upward modulo N.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any
);

  int w_idx;

  // Rotating priority search; modulo keeps an out-of-range ptr safe.
  always_comb begin
    grant     = {N{1'b0}};
    grant_idx = {SELW{1'b0}};
    any       = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (!any && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_idx    = SELW'(w_idx);
        any          = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-way arbitrating mux with registered output stage and valid/ready on every port.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = clog2_min1(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_src
);

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_src;
  logic             r_out_valid;
  logic [SELW-1:0]  r_rr_ptr;

  logic [N-1:0]     w_sel_grant;
  logic [N-1:0]     w_rr_grant;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_rr_any;
  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_idx;
  logic             w_has_grant;
  logic             w_can_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_word;

  rr_arbiter #(.N(N), .SELW(SELW)) u_rr (
    .req       (in_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_rr_grant),
    .grant_idx (w_rr_idx),
    .any       (w_rr_any)
  );

  // Explicit select; an index >= N matches no channel and so grants nothing.
  always_comb begin
    w_sel_grant = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_sel_grant[i] = in_valid[i] & (sel == SELW'(i));
    end
  end

  // Pick the active arbitration path.
  always_comb begin
    w_grant     = {N{1'b0}};
    w_idx       = {SELW{1'b0}};
    w_has_grant = 1'b0;
    case (mode)
      MODE_RR: begin
        w_grant     = w_rr_grant;
        w_idx       = w_rr_idx;
        w_has_grant = w_rr_any;
      end
      MODE_SEL: begin
        w_grant     = w_sel_grant;
        w_idx       = sel;
        w_has_grant = |w_sel_grant;
      end
      default: begin
        w_grant     = {N{1'b0}};
        w_idx       = {SELW{1'b0}};
        w_has_grant = 1'b0;
      end
    endcase
  end

  assign w_can_load = ~r_out_valid | out_ready;
  assign w_xfer     = w_has_grant & w_can_load;
  assign in_ready   = w_grant & {N{w_can_load}};

  // One-hot data mux driven by the same grant that raises in_ready.
  always_comb begin
    w_word = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_word = in_data[i*WIDTH +: WIDTH];
      end else begin
        w_word = w_word;
      end
    end
  end

  // Output register and round-robin pointer; the pointer moves only on rr transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= {WIDTH{1'b0}};
      r_out_src   <= {SELW{1'b0}};
      r_out_valid <= 1'b0;
      r_rr_ptr    <= {SELW{1'b0}};
    end else if (w_xfer) begin
      r_out_data  <= w_word;
      r_out_src   <= w_idx;
      r_out_valid <= 1'b1;
      if (mode == MODE_RR) begin
        r_rr_ptr <= (w_idx == SELW'(N-1)) ? {SELW{1'b0}} : (w_idx + SELW'(1));
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_arb_mux.sv
// Directed self-checking bench for arb_mux (N=4 main instance, N=3 for out-of-range select).
module tb_arb_mux;

  logic         clk;
  logic         rst_n;

  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic         mode;
  logic [1:0]   sel;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_src;

  logic [95:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic         mode3;
  logic [1:0]   sel3;
  logic [31:0]  out_data3;
  logic         out_valid3;
  logic         out_ready3;
  logic [1:0]   out_src3;

  int n_cmp;
  int n_bad;

  arb_mux #(.WIDTH(32), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
  );

  arb_mux #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_src(out_src3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] exp_src;
    rst_n = 1'b0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid actual=%0b required=0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_data actual=%h required=0", out_data); end
    n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL rst_src actual=%0d required=0", out_src); end
    tick();
    rst_n = 1'b1;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL first_grant actual=%b required=0001", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'hA0) begin
      n_bad++; $display("FAIL first_word actual=%0b/%0d/%h required=1/0/a0", out_valid, out_src, out_data); end
    // out_valid is 1 here and rr_ptr has advanced to 1: reset mid-stream
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin
      n_bad++; $display("FAIL mid_rst actual=%0b/%h/%0d required=0/0/0", out_valid, out_data, out_src); end
    rst_n = 1'b1;
    exp_src = 2'd0;
    tick();
    n_cmp++; if (out_src !== exp_src || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL post_rst_src actual=%0d/%0b required=%0d/1", out_src, out_valid, exp_src); end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_explicit();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL sel_ready cyc%0d actual=%b required=0100", c, in_ready); end
      tick();
      n_cmp++; if (out_data !== 32'hA2 || out_src !== 2'd2 || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL sel_out cyc%0d actual=%h/%0d/%0b required=a2/2/1", c, out_data, out_src, out_valid); end
    end
    in_valid = 4'b0000;
    mode3 = 1'b0; sel3 = 2'd1; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    n_cmp++; if (in_ready3 !== 3'b010) begin n_bad++; $display("FAIL n3_ready actual=%b required=010", in_ready3); end
    tick();
    n_cmp++; if (out_valid3 !== 1'b1 || out_src3 !== 2'd1 || out_data3 !== 32'hB1) begin
      n_bad++; $display("FAIL n3_word actual=%0b/%0d/%h required=1/1/b1", out_valid3, out_src3, out_data3); end
    sel3 = 2'd3;
    #1;
    n_cmp++; if (in_ready3 !== 3'b000) begin n_bad++; $display("FAIL n3_oob_ready actual=%b required=000", in_ready3); end
    tick();
    n_cmp++; if (out_valid3 !== 1'b0) begin n_bad++; $display("FAIL n3_drain actual=%0b required=0", out_valid3); end
    in_valid3 = 3'b000;
  endtask

  task automatic test_rr_fair();
    logic [1:0]  es;
    logic [3:0]  er;
    logic [31:0] ed;
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      es = 2'(c % 4);
      er = 4'b0001 << es;
      ed = 32'hA0 + 32'(es);
      #1;
      n_cmp++; if (in_ready !== er) begin n_bad++; $display("FAIL rr_ready cyc%0d actual=%b required=%b", c, in_ready, er); end
      tick();
      n_cmp++; if (out_src !== es || out_data !== ed || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL rr_out cyc%0d actual=%0d/%h required=%0d/%h", c, out_src, out_data, es, ed); end
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_rr_skip();
    logic [1:0] es;
    do_reset();
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      es = (c % 2 == 0) ? 2'd1 : 2'd3;
      tick();
      n_cmp++; if (out_src !== es || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL rr_skip cyc%0d actual=%0d required=%0d", c, out_src, es); end
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    int sent;
    int recv;
    sent = 0; recv = 0;
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    if (|in_ready) sent++;
    if (out_valid && out_ready) recv++;
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready cyc%0d actual=%b required=0000", c, in_ready); end
      if (|in_ready) sent++;
      if (out_valid && out_ready) recv++;
      tick();
      n_cmp++; if (out_src !== 2'd0 || out_data !== 32'hA0 || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL bp_hold cyc%0d actual=%0d/%h/%0b required=0/a0/1", c, out_src, out_data, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_release_ready actual=%b required=0010", in_ready); end
    if (|in_ready) sent++;
    if (out_valid && out_ready) recv++;
    tick();
    n_cmp++; if (out_src !== 2'd1 || out_data !== 32'hA1 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_release_word actual=%0d/%h required=1/a1", out_src, out_data); end
    in_valid = 4'b0000;
    #1;
    if (|in_ready) sent++;
    if (out_valid && out_ready) recv++;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain actual=%0b required=0", out_valid); end
    n_cmp++; if (sent !== recv || sent !== 2) begin
      n_bad++; $display("FAIL bp_count sent=%0d recv=%0d required=2/2", sent, recv); end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL ms_rr0 actual=%0d required=0", out_src); end
    tick();
    n_cmp++; if (out_src !== 2'd1) begin n_bad++; $display("FAIL ms_rr1 actual=%0d required=1", out_src); end
    mode = 1'b0; sel = 2'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (out_src !== 2'd0 || out_data !== 32'hA0) begin
        n_bad++; $display("FAIL ms_sel cyc%0d actual=%0d/%h required=0/a0", c, out_src, out_data); end
    end
    mode = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL ms_resume_ready actual=%b required=0100", in_ready); end
    tick();
    n_cmp++; if (out_src !== 2'd2 || out_data !== 32'hA2) begin
      n_bad++; $display("FAIL ms_resume actual=%0d/%h required=2/a2", out_src, out_data); end
    in_valid = 4'b0000;
    tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
    for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = 32'hB0 + 32'(i);
    in_valid = 4'b0000; mode = 1'b0; sel = 2'd0; out_ready = 1'b0;
    in_valid3 = 3'b000; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
    test_reset();
    test_explicit();
    test_rr_fair();
    test_rr_skip();
    test_backpressure();
    test_mode_switch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
